// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: per-stage freeze/flush/bubble controller for a 5-stage pipeline.
// Owns a RUN/MEM_WAIT FSM for multi-cycle SRAM accesses with a sticky timeout guard.
// Optional performance counters are enabled with `define STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_freeze,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        UNUSED   = 2'd2
    } state_t;

    localparam int unsigned           WCNT_W      = 16;
    localparam logic [WCNT_W-1:0]     TIMEOUT_LIM = WCNT_W'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 1..65535");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_hit;
    logic              mem_stall;

    // A dropped mem_req while waiting is indistinguishable from completion.
    assign mem_stall = mem_req & ~mem_ready;
    assign state_o   = state;

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt >= TIMEOUT_LIM) begin
                        timeout_hit = 1'b1;
                    end else begin
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Pipeline controls: combinational from state and inputs, forced low in reset.
    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_freeze = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst && (state == RUN || state == MEM_WAIT)) begin
            if (mem_stall) begin
                pc_freeze    = 1'b1;
                ifid_freeze  = 1'b1;
                exmem_freeze = 1'b1;
                memwb_bubble = 1'b1;
            end else if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hazard_detected) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (pc_freeze && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (ifid_flush && flush_events != '1) begin
                flush_events <= flush_events + 1'b1;
            end
            if (state == MEM_WAIT && mem_wait_cycles != '1) begin
                mem_wait_cycles <= mem_wait_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl against a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic hazard_detected, branch_taken, mem_req, mem_ready;
    logic pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, memwb_bubble;
    logic mem_timeout;
    logic [1:0] state_o;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

    int tests = 0;
    int fails = 0;

    // Model: whether the pipe is waiting on memory, how many wait cycles so far.
    bit     m_waiting;
    int     m_waited;
    bit     m_to;
    longint m_stall_c, m_flush_c, m_memw_c;
    logic [5:0] m_outs;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_freeze(exmem_freeze), .memwb_bubble(memwb_bubble),
        .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef STALL_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events),
        .mem_wait_cycles(mem_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] dut_outs();
        return {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, exmem_freeze, memwb_bubble};
    endfunction

    // Expected controls from the priority rules: memory stall, then branch, then hazard.
    function automatic logic [5:0] model_outs(bit h, bit b, bit rq, bit rd);
        if (rq && !rd) return 6'b110011;
        if (b)         return 6'b001100;
        if (h)         return 6'b110100;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_waited = 0; m_to = 0;
        m_stall_c = 0; m_flush_c = 0; m_memw_c = 0;
    endtask

    // One clock cycle: apply inputs, check mid-cycle, then advance the model at the edge.
    task automatic cycle(input bit h, input bit b, input bit rq, input bit rd, input string tag);
        bit stall;
        hazard_detected = h; branch_taken = b; mem_req = rq; mem_ready = rd;
        #2;
        stall  = rq && !rd;
        m_outs = model_outs(h, b, rq, rd);
        chk({tag, ".outs"},  64'(dut_outs()), 64'(m_outs));
        chk({tag, ".state"}, 64'(state_o), m_waiting ? 64'd1 : 64'd0);
        chk({tag, ".tmo"},   64'(mem_timeout), 64'(m_to));
`ifdef STALL_PERF_CNT_EN
        chk({tag, ".stallc"}, 64'(stall_cycles), 64'(m_stall_c));
        chk({tag, ".flushc"}, 64'(flush_events), 64'(m_flush_c));
        chk({tag, ".memwc"},  64'(mem_wait_cycles), 64'(m_memw_c));
`endif
        @(posedge clk);
        if (m_outs[5]) m_stall_c++;
        if (m_outs[3]) m_flush_c++;
        if (m_waiting) m_memw_c++;
        if (!m_waiting) begin
            if (stall) begin m_waiting = 1; m_waited = 1; end
        end else if (!stall) begin
            m_waiting = 0;
        end else if (m_waited >= TO) begin
            m_to = 1; m_waiting = 0;
        end else begin
            m_waited++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset with stall inputs driven: outputs must stay low.
        rst = 1'b1;
        hazard_detected = 1'b1; branch_taken = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        #2;
        chk("reset.outs",  64'(dut_outs()), 64'd0);
        chk("reset.state", 64'(state_o), 64'd0);
        chk("reset.tmo",   64'(mem_timeout), 64'd0);
        do_reset();

        // Hazard held two cycles, then branch over hazard.
        cycle(0, 0, 0, 0, "idle");
        cycle(1, 0, 0, 0, "haz1");
        cycle(1, 0, 0, 0, "haz2");
        cycle(0, 0, 0, 0, "haz_end");
        cycle(1, 1, 0, 0, "br_haz");

        // Three-cycle memory stall completing on the fourth.
        cycle(0, 0, 1, 0, "mem0");
        cycle(0, 1, 1, 0, "mem1");
        cycle(1, 0, 1, 0, "mem2");
`ifdef STALL_PERF_CNT_EN
        chk("mem3.memwc_before", 64'(mem_wait_cycles), 64'd2);
`endif
        cycle(1, 0, 1, 1, "mem3");
        chk("mem_done.state", 64'(state_o), 64'd0);
        cycle(0, 0, 0, 0, "mem_idle");

        // mem_req dropping while waiting acts as completion.
        cycle(0, 0, 1, 0, "drop0");
        cycle(0, 1, 0, 0, "drop1");

        // Timeout: stall held through four wait cycles.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, "tmo_run");
        chk("tmo.flag", 64'(mem_timeout), 64'd1);
        chk("tmo.state", 64'(state_o), 64'd0);
        cycle(0, 0, 0, 0, "tmo_after1");
        cycle(1, 0, 0, 0, "tmo_after2");

        // Asynchronous reset while waiting on memory.
        cycle(0, 0, 1, 0, "rw0");
        hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        #2;
        chk("rw.pre_state", 64'(state_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rw.outs",  64'(dut_outs()), 64'd0);
        chk("rw.state", 64'(state_o), 64'd0);
        chk("rw.tmo",   64'(mem_timeout), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Five hazards plus one branch for the counters.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, "perf_haz");
        cycle(0, 1, 0, 0, "perf_br");
        cycle(0, 0, 0, 0, "perf_idle");
`ifdef STALL_PERF_CNT_EN
        chk("perf.stall5", 64'(stall_cycles), 64'd6 - 64'd1);
        chk("perf.flush1", 64'(flush_events), 64'd1);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer end of the hazard-detection interface: takes the ID-stage hazard_detected flag, the EX-stage branch_taken flag and the MEM-stage SRAM handshake.
- Produces every per-stage freeze, flush and bubble control for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Owns a small FSM for multi-cycle memory waits, with a timeout guard and optional performance counters.

Parameters:
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before abort; legal range 1..65535
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- hazard_detected  in  1  RAW hazard on the ID-stage instruction
- branch_taken  in  1  EX-stage branch/jump resolved taken
- mem_req  in  1  MEM stage has an SRAM read/write this cycle
- mem_ready  in  1  SRAM completes the access this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  zero ID/EX control (wb_en, mem_r, mem_w, branch)
- exmem_freeze  out  1  hold ID/EX and EX/MEM registers
- memwb_bubble  out  1  zero MEM/WB wb_en
- mem_timeout  out  1  sticky error, cleared only by rst
- state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (async, immediate): state=RUN, wait counter=0, mem_timeout=0, counters=0. All freeze/flush/bubble outputs are driven 0 whenever rst=1.
- Outputs are combinational from state plus inputs: zero-cycle latency, same cycle as the cause. State, counter and mem_timeout update on the rising edge of clk.
- States: RUN=2'd0, MEM_WAIT=2'd1. Encoding 2'd2 is unused; if ever reached, go to RUN next cycle with all outputs 0.
- mem_stall = mem_req & ~mem_ready.
- RUN priority, highest first:
  - (1) mem_stall: pc_freeze=ifid_freeze=exmem_freeze=1, memwb_bubble=1. Next state MEM_WAIT, wait counter loads 1. branch_taken and hazard_detected are ignored this cycle (pipe frozen, both re-evaluated later).
  - (2) branch_taken: ifid_flush=1, idex_bubble=1, no freezes. hazard_detected is ignored (the ID instruction is wrong-path).
  - (3) hazard_detected: pc_freeze=ifid_freeze=1, idex_bubble=1.
  - (4) otherwise all outputs 0.
- MEM_WAIT:
  - While mem_ready=0: same four outputs as RUN(1), wait counter increments.
  - mem_ready=1: freezes drop that cycle; RUN rules (2)/(3) apply this cycle; next state RUN, wait counter cleared.
  - Counter reaches MEM_TIMEOUT with mem_ready=0: set mem_timeout=1, force next state RUN, and drive outputs as RUN(1) in that cycle. Memory completion is abandoned; the next cycle behaves as normal RUN.
  - mem_req dropping to 0 while in MEM_WAIT is treated as mem_ready=1.
- Counter saturates; never wraps.
- A hazard with no other event lasts as long as hazard_detected is held, one bubble per cycle; no internal hazard state.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: adds outputs stall_cycles, flush_events and mem_wait_cycles, each CNT_W bits.
  - stall_cycles: +1 on every cycle pc_freeze=1.
  - flush_events: +1 on every cycle ifid_flush=1.
  - mem_wait_cycles: +1 on every cycle state=MEM_WAIT.
  - All reset to 0, saturate at all-ones.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- hazard_detected=1 for 2 cycles, others 0 -> pc_freeze=ifid_freeze=idex_bubble=1 exactly those 2 cycles; state stays RUN.
- branch_taken=1 and hazard_detected=1 in the same cycle -> ifid_flush=idex_bubble=1, pc_freeze=0.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> exmem_freeze=1 for 3 cycles, 0 on the 4th; state_o sequence 0,1,1,1 then 0; if the macro is defined, mem_wait_cycles=2.
- MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> mem_timeout rises after the 4th MEM_WAIT cycle, state returns to 0 and mem_timeout stays 1.
- rst asserted mid-MEM_WAIT -> all outputs 0 immediately, state_o=0, mem_timeout=0.
- With STALL_PERF_CNT_EN defined: 5 hazard cycles plus 1 branch -> stall_cycles=5, flush_events=1.
